// File: rtl/reg_dump_uart_if.sv
// Register-dump port bundle: start/busy/done handshake, the register-file
// read port (ra/rd) and the UART TX line.
interface reg_dump_uart_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        tx;
  logic [4:0]  ra;
  logic [31:0] rd;

  // System / register-file side: requests dumps and supplies read data.
  modport master (
    output start,
    output rd,
    input  busy,
    input  done,
    input  tx,
    input  ra
  );

  // Dump engine side.
  modport slave (
    input  start,
    input  rd,
    output busy,
    output done,
    output tx,
    output ra
  );
endinterface

// File: rtl/reg_dump_uart.sv
// Walks register-file entries 0..NUM_REGS-1 and streams a header byte followed
// by each 32-bit word (big-endian) on an 8N1 UART line.
module reg_dump_uart #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          NUM_REGS     = 32,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_dump_uart_if.slave bus
);

  localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   BAUD_ONE  = BW'(1);
  localparam logic [4:0]      IDX_LAST  = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LOAD = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t         state_r;
  logic [BW-1:0]  baud_r;
  logic [3:0]     bit_cnt_r;
  logic [1:0]     byte_cnt_r;
  logic [4:0]     idx_r;
  logic [7:0]     shreg_r;
  logic [31:0]    word_r;
  logic [4:0]     ra_r;
  logic           tx_r;
  logic           busy_r;
  logic           done_r;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    byte_sel = w[31:24];
      2'd1:    byte_sel = w[23:16];
      2'd2:    byte_sel = w[15:8];
      default: byte_sel = w[7:0];
    endcase
  endfunction

  assign bus.tx   = tx_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.ra   = ra_r;

  // Dump sequencer and bit serialiser; bit_cnt 0 = start, 1..8 = data, 9 = stop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      baud_r     <= '0;
      bit_cnt_r  <= 4'd0;
      byte_cnt_r <= 2'd0;
      idx_r      <= 5'd0;
      shreg_r    <= 8'd0;
      word_r     <= 32'd0;
      ra_r       <= 5'd0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r   <= HDR;
            busy_r    <= 1'b1;
            idx_r     <= 5'd0;
            shreg_r   <= HEADER;
            bit_cnt_r <= 4'd0;
            baud_r    <= '0;
            tx_r      <= 1'b0;
          end
        end
        HDR, SEND: begin
          if (baud_r == BAUD_LAST) begin
            baud_r <= '0;
            if (bit_cnt_r == 4'd9) begin
              // Frame complete: chain the next byte, fetch the next word, or finish.
              if (state_r == HDR) begin
                state_r <= LOAD;
                ra_r    <= idx_r;
              end else if (byte_cnt_r != 2'd3) begin
                byte_cnt_r <= byte_cnt_r + 2'd1;
                shreg_r    <= byte_sel(word_r, byte_cnt_r + 2'd1);
                bit_cnt_r  <= 4'd0;
                tx_r       <= 1'b0;
              end else if (idx_r == IDX_LAST) begin
                state_r <= DONE;
                done_r  <= 1'b1;
              end else begin
                idx_r   <= idx_r + 5'd1;
                ra_r    <= idx_r + 5'd1;
                state_r <= LOAD;
              end
            end else if (bit_cnt_r == 4'd8) begin
              tx_r      <= 1'b1;
              bit_cnt_r <= 4'd9;
            end else begin
              tx_r      <= shreg_r[0];
              shreg_r   <= {1'b0, shreg_r[7:1]};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end
        LOAD: begin
          // ra already points at idx_r, so rd is this register's current value.
          word_r     <= bus.rd;
          shreg_r    <= byte_sel(bus.rd, 2'd0);
          byte_cnt_r <= 2'd0;
          bit_cnt_r  <= 4'd0;
          baud_r     <= '0;
          tx_r       <= 1'b0;
          state_r    <= SEND;
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
